// File: rtl/ftoi_seq.sv
// Multi-cycle float32 to int32 converter with truncation toward zero.
// The operand is classified at accept; normal values are denormalised by an
// iterative barrel step of up to STEP bits per cycle, then the sign is applied.
module ftoi_seq #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] s,
  output logic        ovf,
  output logic        inexact
);

  localparam logic [4:0]         STEP_AMT = 5'(STEP);
  localparam logic signed [31:0] INT_MAX  = 32'sh7FFFFFFF;
  localparam logic signed [31:0] INT_MIN  = 32'sh80000000;

  typedef enum logic [1:0] {IDLE, SHIFT, NEGATE, DONE} state_t;

  state_t             state, state_nx;
  logic [31:0]        mag;
  logic [4:0]         rem;
  logic               left;
  logic               sticky;
  logic               neg;
  logic signed [31:0] s_q;
  logic               ovf_q;
  logic               inexact_q;

  logic [7:0]  exp_f;
  logic [22:0] man_f;
  logic        is_nan, is_inf, is_big, is_small, is_special, left_in;
  logic [4:0]  d_in;
  logic [4:0]  amt;
  logic [31:0] mask;
  logic [31:0] mag_sh;
  logic        lost;

  // Out-of-range inputs clamp to the int32 extreme matching their sign.
  function automatic logic signed [31:0] sat_by_sign(input logic sgn);
    return sgn ? INT_MIN : INT_MAX;
  endfunction

  // Magnitude is always below 2^31 here, so negation cannot overflow.
  function automatic logic signed [31:0] apply_sign(input logic sgn, input logic [31:0] m);
    logic signed [31:0] sm;
    sm = signed'(m);
    return sgn ? -sm : sm;
  endfunction

  assign exp_f = a[30:23];
  assign man_f = a[22:0];

  // Classify the incoming operand and derive the shift distance to 2^0.
  always_comb begin
    is_nan     = (exp_f == 8'hFF) && (man_f != 23'd0);
    is_inf     = (exp_f == 8'hFF) && (man_f == 23'd0);
    is_big     = (exp_f >= 8'd158) && (exp_f != 8'hFF);
    is_small   = (exp_f < 8'd127);
    is_special = is_nan | is_inf | is_big | is_small;
    left_in    = (exp_f > 8'd150);
    d_in       = left_in ? 5'(exp_f - 8'd150) : 5'(8'd150 - exp_f);
  end

  // One shift step: at most STEP bits, collecting discarded bits on right shifts.
  always_comb begin
    amt    = (rem < STEP_AMT) ? rem : STEP_AMT;
    mask   = (32'd1 << amt) - 32'd1;
    lost   = |(mag & mask);
    mag_sh = left ? (mag << amt) : (mag >> amt);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (is_special)         state_nx = DONE;
          else if (d_in != 5'd0)  state_nx = SHIFT;
          else                    state_nx = NEGATE;
        end
      end
      SHIFT:  if (rem == amt) state_nx = NEGATE;
      NEGATE: state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand unpack, iterative denormalise and result formation.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q       <= '0;
      ovf_q     <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          neg    <= a[31];
          sticky <= 1'b0;
          mag    <= {8'b0, 1'b1, man_f};
          left   <= left_in;
          rem    <= d_in;
          if (is_nan) begin
            s_q <= INT_MAX;  ovf_q <= 1'b1;  inexact_q <= 1'b0;
          end else if (is_inf) begin
            s_q <= sat_by_sign(a[31]);  ovf_q <= 1'b1;  inexact_q <= 1'b0;
          end else if (is_big) begin
            // -2^31 is the one e>=31 value that is exactly representable.
            if (a == 32'hCF000000) begin
              s_q <= INT_MIN;  ovf_q <= 1'b0;
            end else begin
              s_q <= sat_by_sign(a[31]);  ovf_q <= 1'b1;
            end
            inexact_q <= 1'b0;
          end else if (is_small) begin
            s_q <= '0;  ovf_q <= 1'b0;  inexact_q <= |a[30:0];
          end
        end
        SHIFT: begin
          mag    <= mag_sh;
          sticky <= sticky | (lost & ~left);
          rem    <= rem - amt;
        end
        NEGATE: begin
          s_q       <= apply_sign(neg, mag);
          ovf_q     <= 1'b0;
          inexact_q <= sticky;
        end
        default: ;
      endcase
    end
  end

  assign s       = s_q;
  assign ovf     = ovf_q;
  assign inexact = inexact_q;

endmodule

// File: tb/tb_ftoi_seq.sv
// Directed bench for ftoi_seq: two instances (STEP=1 and STEP=8) share the
// operand bus so each vector checks results and both latencies.
module tb_ftoi_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, ordy1, ordy8;
  logic [31:0] a;
  logic        ir1, ov1, ovf1, inx1, ir8, ov8, ovf8, inx8;
  logic [31:0] s1, s8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ftoi_seq #(.STEP(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .a(a),
    .out_valid(ov1), .out_ready(ordy1), .s(s1), .ovf(ovf1), .inexact(inx1)
  );

  ftoi_seq #(.STEP(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8), .a(a),
    .out_valid(ov8), .out_ready(ordy8), .s(s8), .ovf(ovf8), .inexact(inx8)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] s;
    logic        ovf;
    logic        inx;
    int          lat1;
    int          lat8;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand, measure latency on both instances, check, then drain.
  task automatic conv(input vec_t v, input string tag);
    int cyc;
    int l1, l8;
    logic [31:0] cs1, cs8;
    logic cf1, ci1, cf8, ci8;
    l1 = 0; l8 = 0;
    cs1 = '0; cs8 = '0; cf1 = 0; ci1 = 0; cf8 = 0; ci8 = 0;
    a = v.a;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 1;
    while (cyc < 64) begin
      if (l1 == 0 && ov1) begin l1 = cyc; cs1 = s1; cf1 = ovf1; ci1 = inx1; end
      if (l8 == 0 && ov8) begin l8 = cyc; cs8 = s8; cf8 = ovf8; ci8 = inx8; end
      if (l1 != 0 && l8 != 0) break;
      tick();
      cyc++;
    end
    chk({tag, " s step1"}, cs1, v.s);
    chk({tag, " ovf step1"}, 32'(cf1), 32'(v.ovf));
    chk({tag, " inexact step1"}, 32'(ci1), 32'(v.inx));
    chk({tag, " latency step1"}, 32'(l1), 32'(v.lat1));
    chk({tag, " s step8"}, cs8, v.s);
    chk({tag, " ovf step8"}, 32'(cf8), 32'(v.ovf));
    chk({tag, " inexact step8"}, 32'(ci8), 32'(v.inx));
    chk({tag, " latency step8"}, 32'(l8), 32'(v.lat8));
    // Results must still be held when the consumer finally takes them.
    chk({tag, " s held step1"}, s1, v.s);
    chk({tag, " s held step8"}, s8, v.s);
    ordy1 = 1'b1;
    ordy8 = 1'b1;
    tick();
    ordy1 = 1'b0;
    ordy8 = 1'b0;
    chk({tag, " back to idle step1"}, 32'(ir1), 32'd1);
    chk({tag, " back to idle step8"}, 32'(ir8), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int k;
    vecs[0]  = '{32'h40490FDB, 32'h00000003, 1'b0, 1'b1, 24, 5};  // pi
    vecs[1]  = '{32'hC2F60000, 32'hFFFFFF85, 1'b0, 1'b0, 19, 5};  // -123.0
    vecs[2]  = '{32'h4B800000, 32'h01000000, 1'b0, 1'b0, 3, 3};   // 2^24
    vecs[3]  = '{32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1, 1};   // 2^31
    vecs[4]  = '{32'hCF000000, 32'h80000000, 1'b0, 1'b0, 1, 1};   // -2^31
    vecs[5]  = '{32'h7FC00000, 32'h7FFFFFFF, 1'b1, 1'b0, 1, 1};   // NaN
    vecs[6]  = '{32'hFF800000, 32'h80000000, 1'b1, 1'b0, 1, 1};   // -Inf
    vecs[7]  = '{32'h3F000000, 32'h00000000, 1'b0, 1'b1, 1, 1};   // 0.5
    vecs[8]  = '{32'h80000000, 32'h00000000, 1'b0, 1'b0, 1, 1};   // -0.0
    vecs[9]  = '{32'h4B000001, 32'h00800001, 1'b0, 1'b0, 2, 2};   // e=23
    vecs[10] = '{32'h3F800000, 32'h00000001, 1'b0, 1'b0, 25, 5};  // 1.0
    vecs[11] = '{32'hBFC00000, 32'hFFFFFFFF, 1'b0, 1'b1, 25, 5};  // -1.5
    vecs[12] = '{32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0, 9, 3};   // max e=30
    vecs[13] = '{32'hCEFFFFFF, 32'h80000080, 1'b0, 1'b0, 9, 3};   // -max e=30
    vecs[14] = '{32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0, 1, 1};   // +Inf
    vecs[15] = '{32'h00000001, 32'h00000000, 1'b0, 1'b1, 1, 1};   // denormal

    rst = 1'b1; in_valid = 1'b0; ordy1 = 1'b0; ordy8 = 1'b0; a = '0;
    tick();
    tick();
    chk("reset in_ready", 32'({ir1, ir8}), 32'b11);
    chk("reset out_valid", 32'({ov1, ov8}), 32'b00);
    chk("reset s step1", s1, 32'h0);
    chk("reset flags", 32'({ovf1, inx1, ovf8, inx8}), 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) conv(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held in DONE, new operands ignored.
    a = 32'hC2F60000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    k = 0;
    while (!(ov1 && ov8) && k < 64) begin tick(); k++; end
    chk("bp reached done", 32'({ov1, ov8}), 32'b11);
    a = 32'h40490FDB;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp s1 c%0d", c), s1, 32'hFFFFFF85);
      chk($sformatf("bp s8 c%0d", c), s8, 32'hFFFFFF85);
      chk($sformatf("bp flags c%0d", c), 32'({ovf1, inx1, ovf8, inx8}), 32'h0);
      chk($sformatf("bp in_ready c%0d", c), 32'({ir1, ir8}), 32'b00);
      chk($sformatf("bp out_valid c%0d", c), 32'({ov1, ov8}), 32'b11);
    end
    ordy1 = 1'b1;
    ordy8 = 1'b1;
    tick();
    ordy1 = 1'b0;
    ordy8 = 1'b0;
    chk("bp released idle", 32'({ir1, ir8, ov1, ov8}), 32'b1100);
    tick();
    chk("bp next accepted", 32'({ir1, ir8}), 32'b00);
    in_valid = 1'b0;
    k = 0;
    while (!(ov1 && ov8) && k < 64) begin tick(); k++; end
    chk("bp next s1", s1, 32'h00000003);
    chk("bp next s8", s8, 32'h00000003);
    ordy1 = 1'b1;
    ordy8 = 1'b1;
    tick();
    ordy1 = 1'b0;
    ordy8 = 1'b0;

    // Reset during SHIFT discards the operand.
    a = 32'h40490FDB;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid busy", 32'({ir1, ir8, ov1, ov8}), 32'b0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid rst in_ready", 32'({ir1, ir8}), 32'b11);
    chk("mid rst out_valid", 32'({ov1, ov8}), 32'b00);
    chk("mid rst s1", s1, 32'h0);
    chk("mid rst s8", s8, 32'h0);
    v = vecs[1];
    conv(v, "post reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ftoi_seq.md
Name: ftoi_seq

Overview:
- Multi-cycle IEEE-754 single-precision to signed 32-bit integer converter.
- Unpacks a float: splits sign, exponent and mantissa, denormalises by iterative shifting, then applies sign.
- Rounding is truncation toward zero (C cast semantics).
- Sits beside the float add/sub units in the ALU float path; valid/ready on both sides.

Parameters:
STEP, 1, bits shifted per SHIFT cycle; power of two, 1..8.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand a valid
in_ready  output  1  converter can accept an operand
a  input  32  float32 operand
out_valid  output  1  result s valid
out_ready  input  1  consumer accepts result
s  output  32  signed int32 result, two's complement
ovf  output  1  invalid/overflow flag, qualified by out_valid
inexact  output  1  nonzero fraction bits discarded, qualified by out_valid

Behaviour:
- Reset: state=IDLE; in_ready=1, out_valid=0, s=0, ovf=0, inexact=0.
- Reset applied mid-operation discards the in-flight operand and returns to IDLE next cycle.
- States: IDLE, SHIFT, NEGATE, DONE.
- in_ready=1 only in IDLE. Accept occurs on an edge with in_valid=1 in IDLE. a is sampled only at accept.
- Classification at accept. Let E=a[30:23] and e=E-127.
  - E==255, mantissa!=0 (NaN): s=0x7FFFFFFF, ovf=1, inexact=0 -> DONE.
  - E==255, mantissa==0 (Inf): s=0x7FFFFFFF if sign=0, else 0x80000000; ovf=1 -> DONE.
  - e>=31: a==0xCF000000 gives s=0x80000000, ovf=0. Otherwise saturate by sign as for Inf, ovf=1 -> DONE.
  - e<0, including zeros and denormals: s=0, ovf=0. inexact=1 iff a[30:0]!=0 -> DONE.
  - Otherwise load mag={8'b0,1'b1,a[22:0]} and d=|e-23|. Direction is left if e>23, right if e<23. Clear sticky.
    - -> SHIFT if d>0, else -> NEGATE.
- SHIFT:
  - Each cycle shift mag by min(STEP, remaining) in the chosen direction and decrement remaining.
  - On right shifts, OR every bit shifted out into sticky.
  - When remaining reaches 0 -> NEGATE. Cycles spent in SHIFT: n=ceil(d/STEP).
  - Left shifts never lose bits, since e<=30 keeps mag below 2^31.
- NEGATE (one cycle): s = sign ? (~mag+1) : mag; inexact=sticky; ovf=0 -> DONE.
- DONE:
  - out_valid=1; s, ovf and inexact held stable.
  - On an edge with out_ready=1 -> IDLE and out_valid=0.
  - No new operand is accepted in the same cycle, so accept-to-accept is at least one IDLE cycle.
- Latency, from the accept edge to the first cycle out_valid=1:
  - special and e<0 cases: 1 cycle.
  - normal cases: n+2 cycles.
- s, ovf and inexact are don't-care while out_valid=0, but must not change during DONE.
- Zero result is always positive 0 (no -0 in integers); -0.0 gives s=0.

Test Plan:
- a=0x40490FDB (pi), STEP=1 -> s=3, inexact=1, ovf=0, out_valid 24 cycles after accept (d=22). With STEP=8: 5 cycles.
- a=0xC2F60000 (-123.0) -> s=0xFFFFFF85, inexact=0, ovf=0. a=0x4B800000 (2^24) -> s=0x01000000, one left shift, latency 3.
- a=0x4F000000 -> s=0x7FFFFFFF, ovf=1. a=0xCF000000 -> s=0x80000000, ovf=0. a=0x7FC00000 -> s=0x7FFFFFFF, ovf=1. a=0xFF800000 -> s=0x80000000, ovf=1. All with latency 1.
- a=0x3F000000 (0.5) -> s=0, inexact=1. a=0x80000000 -> s=0, inexact=0. a=0x4B000001 (e=23) -> s=0x00800001, latency 2 (SHIFT skipped).
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> s and flags constant, in_ready=0, second in_valid ignored.
  - Raise out_ready -> IDLE. Next operand accepted one cycle later.
- Reset mid-SHIFT, rst=1 for one cycle during pi conversion -> next cycle IDLE, in_ready=1, out_valid=0, s=0. A following conversion of -123.0 is correct.
